song_sequencer: RTL and testbench

Plays a song by stepping through a song ROM of (note, duration) entries, one entry per note, timed by the beat ticks from the beat_generator chain.
- Drives the note code to the tone generator.
- Enables the beat chain (ci) only while a song is running, so the tempo counters freeze on pause.
- Takes play/pause/stop commands from the debounced key pulses.
- Sits between the key front-end, the song ROM, the beat_generator cascade and the tone generator.

---
 rtl/song_pkg.sv | 32 +++
 rtl/tick_counter.sv | 34 +++
 rtl/song_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_song_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared constants and types for the song sequencer
package song_pkg;

  localparam int SONG_NOTE_BITS = 5;
  localparam int SONG_DUR_BITS  = 3;

  // Note codes with special meaning in the song ROM.
  localparam logic [SONG_NOTE_BITS-1:0] NOTE_REST = '0;
  localparam logic [SONG_NOTE_BITS-1:0] NOTE_END  = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP,
    PAUSED
  } state_t;

  // Substate to return to when a paused note is re-fetched.
  typedef enum logic [1:0] {
    RES_NONE,
    RES_PLAY,
    RES_GAP
  } resume_t;

  typedef struct packed {
    logic [SONG_NOTE_BITS-1:0] note;
    logic [SONG_DUR_BITS-1:0]  dur;
  } entry_t;

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - loadable down-counter of beat ticks
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val (takes priority over en)
//   load_val    value loaded; the counter then needs load_val+1 ticks to finish
//   en          one beat tick to consume; saturates at zero
//   zero        count has reached zero, the next tick ends the interval
module tick_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - steps through a song ROM timed by beat ticks
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   play        pulse: start from IDLE or resume from PAUSED
//   pause       pulse: hold the current position
//   stop        pulse: abort and return to address 0
//   loop_en     level: restart at address 0 at end of song
//   beat_tick   one-cycle pulse from the beat cascade
//   beat_en     enable to the beat cascade (high in PLAY and GAP)
//   rom_addr    registered song ROM address
//   rom_data    {note, dur} read back one cycle after rom_addr changes
//   note_out    note code to the tone generator, 0 = silence
//   playing     high in FETCH, LOAD, PLAY and GAP
//   song_done   one-cycle pulse when the song ends without looping
module song_sequencer
  import song_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int NOTE_BITS = 5,
  parameter int DUR_BITS  = 3,
  parameter int SONG_LEN  = 256,
  parameter int GAP_TICKS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          play,
  input  logic                          pause,
  input  logic                          stop,
  input  logic                          loop_en,
  input  logic                          beat_tick,
  output logic                          beat_en,
  output logic [ADDR_BITS-1:0]          rom_addr,
  input  logic [NOTE_BITS+DUR_BITS-1:0] rom_data,
  output logic [NOTE_BITS-1:0]          note_out,
  output logic                          playing,
  output logic                          song_done
);

  // A zero-width counter is illegal, so legato builds keep a 1-bit stub.
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SONG_LEN - 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(GAP_TICKS - 1);

  state_t  state, nxt;
  resume_t resume, resume_nxt;

  logic [ADDR_BITS-1:0] addr_nxt;
  logic [NOTE_BITS-1:0] note_nxt;
  logic                 done_nxt;

  logic [NOTE_BITS-1:0] rd_note;
  logic [DUR_BITS-1:0]  rd_dur;

  logic cmd_stop, cmd_pause, cmd_play, tick;
  logic dur_load, dur_en, dur_zero;
  logic gap_load, gap_en, gap_zero;
  logic do_adv, do_end;

  assign rd_note = rom_data[NOTE_BITS+DUR_BITS-1:DUR_BITS];
  assign rd_dur  = rom_data[DUR_BITS-1:0];

  // Only commands that actually act in the current state take part in the
  // priority chain; an effective command swallows a coincident beat tick.
  assign cmd_stop  = stop && (state != IDLE);
  assign cmd_pause = !cmd_stop && pause &&
                     ((state == FETCH) || (state == LOAD) ||
                      (state == PLAY)  || (state == GAP));
  assign cmd_play  = !cmd_stop && !cmd_pause && play &&
                     ((state == IDLE) || (state == PAUSED));
  assign tick      = beat_tick && !cmd_stop && !cmd_pause;

  // Remaining duration: loaded with dur, the note ends on the tick seen at zero.
  tick_counter #(.WIDTH(DUR_BITS)) u_dur_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dur_load),
    .load_val (rd_dur),
    .en       (dur_en),
    .zero     (dur_zero)
  );

  tick_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  always_comb begin
    nxt        = state;
    resume_nxt = resume;
    addr_nxt   = rom_addr;
    note_nxt   = note_out;
    done_nxt   = 1'b0;
    dur_load   = 1'b0;
    dur_en     = 1'b0;
    gap_load   = 1'b0;
    gap_en     = 1'b0;
    do_adv     = 1'b0;
    do_end     = 1'b0;

    if (cmd_stop) begin
      nxt        = IDLE;
      addr_nxt   = '0;
      note_nxt   = '0;
      resume_nxt = RES_NONE;
    end else if (cmd_pause) begin
      nxt      = PAUSED;
      note_nxt = '0;
      // A pause during the re-fetch keeps the substate saved earlier.
      if (state == PLAY) begin
        resume_nxt = RES_PLAY;
      end else if (state == GAP) begin
        resume_nxt = RES_GAP;
      end
    end else begin
      case (state)
        IDLE: begin
          note_nxt = '0;
          if (cmd_play) nxt = FETCH;
        end
        FETCH: begin
          nxt = LOAD;
        end
        LOAD: begin
          resume_nxt = RES_NONE;
          if (resume == RES_PLAY) begin
            note_nxt = rd_note;
            nxt      = PLAY;
          end else if (resume == RES_GAP) begin
            note_nxt = '0;
            nxt      = GAP;
          end else if (rd_note == {NOTE_BITS{1'b1}}) begin
            do_end = 1'b1;
          end else begin
            note_nxt = rd_note;
            dur_load = 1'b1;
            nxt      = PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            if (!dur_zero) begin
              dur_en = 1'b1;
            end else if (GAP_TICKS > 0) begin
              note_nxt = '0;
              gap_load = 1'b1;
              nxt      = GAP;
            end else begin
              do_adv = 1'b1;
            end
          end
        end
        GAP: begin
          note_nxt = '0;
          if (tick) begin
            if (gap_zero) do_adv = 1'b1;
            else          gap_en = 1'b1;
          end
        end
        PAUSED: begin
          note_nxt = '0;
          if (cmd_play) nxt = FETCH;
        end
        default: begin
          nxt = IDLE;
        end
      endcase

      if (do_adv) begin
        if (rom_addr == LAST_ADDR) begin
          do_end = 1'b1;
        end else begin
          addr_nxt = rom_addr + 1'b1;
          nxt      = FETCH;
        end
      end

      if (do_end) begin
        addr_nxt   = '0;
        resume_nxt = RES_NONE;
        if (loop_en) begin
          nxt = FETCH;
        end else begin
          nxt      = IDLE;
          note_nxt = '0;
          done_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      resume    <= RES_NONE;
      rom_addr  <= '0;
      note_out  <= '0;
      beat_en   <= 1'b0;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= nxt;
      resume    <= resume_nxt;
      rom_addr  <= addr_nxt;
      note_out  <= note_nxt;
      song_done <= done_nxt;
      // Decoded from the next state so the outputs line up with the state.
      beat_en   <= (nxt == PLAY) || (nxt == GAP);
      playing   <= (nxt != IDLE) && (nxt != PAUSED);
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed self-checking bench for song_sequencer
module tb_song_sequencer;
  import song_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic       beat_tick = 1'b0;
  logic       beat_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [4:0] note_out;
  logic       playing;
  logic       song_done;

  entry_t rom_mem [4];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // rom_addr is registered, so a combinational read is valid one cycle later.
  assign rom_data = rom_mem[rom_addr[1:0]];

  song_sequencer #(
    .ADDR_BITS (8),
    .NOTE_BITS (5),
    .DUR_BITS  (3),
    .SONG_LEN  (4),
    .GAP_TICKS (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .play      (play),
    .pause     (pause),
    .stop      (stop),
    .loop_en   (loop_en),
    .beat_tick (beat_tick),
    .beat_en   (beat_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_out  (note_out),
    .playing   (playing),
    .song_done (song_done)
  );

  function automatic entry_t mk(input int n, input int d);
    entry_t e;
    e.note = n[4:0];
    e.dur  = d[2:0];
    return e;
  endfunction

  task automatic set_rom(input entry_t e0, input entry_t e1, input entry_t e2, input entry_t e3);
    rom_mem[0] = e0;
    rom_mem[1] = e1;
    rom_mem[2] = e2;
    rom_mem[3] = e3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
  endtask

  task automatic start();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_rom(mk(5, 1), mk(7, 0), mk(31, 0), mk(0, 0));

    // Reset values
    step(2);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_note", 32'(note_out), 0);
    chk("rst_beat_en", 32'(beat_en), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_done", 32'(song_done), 0);
    rst_n = 1'b1;
    step(2);

    // Test 1: two notes then END, no loop
    start();
    chk("t1_fetch_playing", 32'(playing), 1);
    chk("t1_fetch_beat_en", 32'(beat_en), 0);
    chk("t1_fetch_addr", 32'(rom_addr), 0);
    step();
    chk("t1_load_note", 32'(note_out), 0);
    step();
    chk("t1_note5", 32'(note_out), 5);
    chk("t1_play_beat_en", 32'(beat_en), 1);
    tick();
    chk("t1_note5_tick1", 32'(note_out), 5);
    step(3);
    chk("t1_note5_hold", 32'(note_out), 5);
    tick();
    chk("t1_gap1_note", 32'(note_out), 0);
    chk("t1_gap1_beat_en", 32'(beat_en), 1);
    tick();
    chk("t1_adv_addr", 32'(rom_addr), 1);
    chk("t1_fetch2_beat_en", 32'(beat_en), 0);
    step(2);
    chk("t1_note7", 32'(note_out), 7);
    tick();
    chk("t1_gap2_note", 32'(note_out), 0);
    tick();
    chk("t1_adv2_addr", 32'(rom_addr), 2);
    step();
    chk("t1_load_end_done", 32'(song_done), 0);
    step();
    chk("t1_done", 32'(song_done), 1);
    chk("t1_idle_playing", 32'(playing), 0);
    chk("t1_idle_addr", 32'(rom_addr), 0);
    step();
    chk("t1_done_single", 32'(song_done), 0);

    // Test 2: same ROM with loop_en
    loop_en = 1'b1;
    start();
    step(2);
    chk("t2_note5", 32'(note_out), 5);
    tick();
    tick();
    tick();
    step(2);
    chk("t2_note7", 32'(note_out), 7);
    tick();
    tick();
    step(2);
    chk("t2_loop_done", 32'(song_done), 0);
    chk("t2_loop_addr", 32'(rom_addr), 0);
    chk("t2_loop_playing", 32'(playing), 1);
    step(2);
    chk("t2_loop_note5", 32'(note_out), 5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t2_stop_playing", 32'(playing), 0);
    loop_en = 1'b0;

    // Test 3: pause after 1 of 4 ticks, resume keeps remaining 3
    set_rom(mk(9, 3), mk(31, 0), mk(31, 0), mk(31, 0));
    start();
    step(2);
    chk("t3_note9", 32'(note_out), 9);
    tick();
    chk("t3_note9_tick1", 32'(note_out), 9);
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("t3_paused_beat_en", 32'(beat_en), 0);
    chk("t3_paused_note", 32'(note_out), 0);
    chk("t3_paused_playing", 32'(playing), 0);
    step(50);
    chk("t3_held_beat_en", 32'(beat_en), 0);
    chk("t3_held_note", 32'(note_out), 0);
    chk("t3_held_addr", 32'(rom_addr), 0);
    start();
    step(2);
    chk("t3_resume_note", 32'(note_out), 9);
    chk("t3_resume_beat_en", 32'(beat_en), 1);
    tick();
    chk("t3_resume_tick1", 32'(note_out), 9);
    tick();
    chk("t3_resume_tick2", 32'(note_out), 9);
    tick();
    chk("t3_resume_tick3_gap", 32'(note_out), 0);
    tick();
    chk("t3_adv_addr", 32'(rom_addr), 1);
    step(2);
    chk("t3_done", 32'(song_done), 1);

    // Test 4: stop with coincident beat_tick in PLAY at addr 3
    set_rom(mk(1, 0), mk(2, 0), mk(3, 0), mk(4, 0));
    start();
    step(2);
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      step(2);
    end
    chk("t4_addr3", 32'(rom_addr), 3);
    chk("t4_note4", 32'(note_out), 4);
    stop = 1'b1;
    beat_tick = 1'b1;
    step();
    stop = 1'b0;
    beat_tick = 1'b0;
    chk("t4_stop_playing", 32'(playing), 0);
    chk("t4_stop_addr", 32'(rom_addr), 0);
    chk("t4_stop_beat_en", 32'(beat_en), 0);
    chk("t4_stop_note", 32'(note_out), 0);
    chk("t4_stop_done", 32'(song_done), 0);
    step();
    chk("t4_stop_done_later", 32'(song_done), 0);

    // Test 5: no END marker, wrap at SONG_LEN-1 without looping
    start();
    step(2);
    for (int i = 0; i < 4; i++) begin
      chk("t5_note", 32'(note_out), i + 1);
      chk("t5_addr", 32'(rom_addr), i);
      tick();
      tick();
      if (i < 3) step(2);
    end
    chk("t5_done", 32'(song_done), 1);
    chk("t5_addr_end", 32'(rom_addr), 0);
    chk("t5_playing_end", 32'(playing), 0);
    step();

    // Test 6: asynchronous reset mid-note
    set_rom(mk(3, 0), mk(12, 7), mk(31, 0), mk(31, 0));
    start();
    step(2);
    tick();
    tick();
    step(2);
    chk("t6_note12", 32'(note_out), 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_note", 32'(note_out), 0);
    chk("t6_async_addr", 32'(rom_addr), 0);
    chk("t6_async_playing", 32'(playing), 0);
    chk("t6_async_beat_en", 32'(beat_en), 0);
    step();
    rst_n = 1'b1;
    step();
    start();
    chk("t6_restart_addr", 32'(rom_addr), 0);
    chk("t6_restart_playing", 32'(playing), 1);
    step(2);
    chk("t6_restart_note", 32'(note_out), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
